// File: rtl/price_frame_rx.sv
// Price frame receiver: hunts for 0xA5, collects a big-endian 32-bit price plus
// XOR checksum, and reports accepted prices, checksum failures and inter-byte timeouts.
module price_frame_rx #(
    parameter int TIMEOUT_CYCLES = 52_083
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [31:0] price_out,
    output logic        price_valid,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count
);

    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [19:0] TMO  = 20'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        HUNT, GET_P3, GET_P2, GET_P1, GET_P0, GET_CHK
    } state_t;

    state_t      state, next;
    logic [31:0] shadow;
    logic [19:0] tcnt;
    logic        accept, cs_bad, tmo;
    logic [7:0]  chk_calc;

    assign chk_calc = shadow[31:24] ^ shadow[23:16] ^ shadow[15:8] ^ shadow[7:0];

    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= next;
    end

    // A byte in the terminal-count cycle takes priority over the timeout.
    always_comb begin
        next   = state;
        accept = 1'b0;
        cs_bad = 1'b0;
        tmo    = 1'b0;
        case (state)
            HUNT: if (rx_ready && rx_data == SYNC) next = GET_P3;
            GET_P3, GET_P2, GET_P1, GET_P0: begin
                if (rx_ready) begin
                    case (state)
                        GET_P3:  next = GET_P2;
                        GET_P2:  next = GET_P1;
                        GET_P1:  next = GET_P0;
                        default: next = GET_CHK;
                    endcase
                end else if (tcnt == TMO) begin
                    tmo  = 1'b1;
                    next = HUNT;
                end
            end
            GET_CHK: begin
                if (rx_ready) begin
                    if (rx_data == chk_calc) accept = 1'b1;
                    else                     cs_bad = 1'b1;
                    next = HUNT;
                end else if (tcnt == TMO) begin
                    tmo  = 1'b1;
                    next = HUNT;
                end
            end
            default: next = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= '0;
            tcnt        <= '0;
            price_out   <= '0;
            price_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            price_valid <= accept;
            frame_err   <= cs_bad | tmo;

            if (rx_ready || state == HUNT || next == HUNT) tcnt <= '0;
            else                                           tcnt <= tcnt + 20'd1;

            if (rx_ready) begin
                case (state)
                    GET_P3:  shadow[31:24] <= rx_data;
                    GET_P2:  shadow[23:16] <= rx_data;
                    GET_P1:  shadow[15:8]  <= rx_data;
                    GET_P0:  shadow[7:0]   <= rx_data;
                    default: ;
                endcase
            end
            if (tmo) shadow <= '0;

            if (accept) begin
                price_out   <= shadow;
                frame_count <= frame_count + 16'd1;
            end
            if (cs_bad) err_code <= 2'd1;
            if (tmo)    err_code <= 2'd2;
            if ((cs_bad || tmo) && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_price_frame_rx.sv
// Directed bench for price_frame_rx with a short timeout.
module tb_price_frame_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic [31:0] price_out;
    logic        price_valid, frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_mis = 0;
    logic both_seen = 1'b0;
    int   err_pulses = 0;

    price_frame_rx #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .price_out(price_out), .price_valid(price_valid), .frame_err(frame_err),
        .err_code(err_code), .frame_count(frame_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (price_valid && frame_err) both_seen <= 1'b1;
        if (frame_err) err_pulses <= err_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe one byte; returns #1 after the edge that samples it.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] p, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(p[31:24]);
        send_byte(p[23:16]);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
        send_byte(c);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic got;
        int   cyc;
        int   ep0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_price",  price_out, 32'h0);
        check("rst_pv",     {31'h0, price_valid}, 32'h0);
        check("rst_fe",     {31'h0, frame_err}, 32'h0);
        check("rst_code",   {30'h0, err_code}, 32'h0);
        check("rst_fcnt",   {16'h0, frame_count}, 32'h0);
        check("rst_ecnt",   {24'h0, err_count}, 32'h0);

        // Good frame
        send_frame(32'h000186A0, 8'h27);
        check("ok_pv",     {31'h0, price_valid}, 32'h1);
        check("ok_price",  price_out, 32'h000186A0);
        check("ok_fcnt",   {16'h0, frame_count}, 32'h1);
        check("ok_noerr",  err_pulses, 0);
        @(posedge clk); #1;
        check("ok_pv_pulse", {31'h0, price_valid}, 32'h0);

        // Bad checksum
        send_frame(32'h000186A0, 8'h00);
        check("cs_fe",    {31'h0, frame_err}, 32'h1);
        check("cs_pv",    {31'h0, price_valid}, 32'h0);
        check("cs_code",  {30'h0, err_code}, 32'h1);
        check("cs_ecnt",  {24'h0, err_count}, 32'h1);
        check("cs_price", price_out, 32'h000186A0);
        @(posedge clk); #1;
        check("cs_fe_pulse", {31'h0, frame_err}, 32'h0);

        // Timeout after partial frame, then recovery
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        got = 1'b0; cyc = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk); #1;
            if (frame_err) begin got = 1'b1; cyc = i; end
        end
        check("tmo_seen",  {31'h0, got}, 32'h1);
        check("tmo_delay", {31'h0, (cyc >= 16 && cyc <= 17)}, 32'h1);
        check("tmo_code",  {30'h0, err_code}, 32'h2);
        check("tmo_ecnt",  {24'h0, err_count}, 32'h2);
        check("tmo_price", price_out, 32'h000186A0);
        send_frame(32'h11223344, 8'h44);
        check("rec_pv",    {31'h0, price_valid}, 32'h1);
        check("rec_price", price_out, 32'h11223344);
        check("rec_fcnt",  {16'h0, frame_count}, 32'h2);

        // Leading garbage ignored
        do_reset();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
        send_frame(32'hDEADBEEF, 8'h22);
        check("gb_pv",    {31'h0, price_valid}, 32'h1);
        check("gb_price", price_out, 32'hDEADBEEF);
        check("gb_ecnt",  {24'h0, err_count}, 32'h0);

        // Reset mid-frame, with a strobe during reset
        send_byte(8'hA5); send_byte(8'h12);
        ep0 = err_pulses;
        @(posedge clk); #1;
        rst = 1'b1;
        send_byte(8'hA5);
        @(posedge clk); #1;
        check("mr_price_rst", price_out, 32'h0);
        rst = 1'b0;
        send_frame(32'h00000007, 8'h07);
        check("mr_pv",    {31'h0, price_valid}, 32'h1);
        check("mr_price", price_out, 32'h00000007);
        check("mr_fcnt",  {16'h0, frame_count}, 32'h1);
        check("mr_noerr", err_pulses - ep0, 0);

        // Byte arriving exactly at the timeout terminal count wins
        ep0 = err_pulses;
        send_byte(8'hA5);
        repeat (15) @(posedge clk);
        send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h05); send_byte(8'h05);
        check("tc_pv",    {31'h0, price_valid}, 32'h1);
        check("tc_price", price_out, 32'h00000005);
        check("tc_noerr", err_pulses - ep0, 0);

        // frame_count wrap
        @(posedge clk); #1;
        force dut.frame_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_count;
        send_frame(32'h01020304, 8'h04);
        check("wr_pv",    {31'h0, price_valid}, 32'h1);
        check("wr_fcnt",  {16'h0, frame_count}, 32'h0);
        check("wr_price", price_out, 32'h01020304);

        // err_count saturation
        do_reset();
        for (int i = 0; i < 256; i++) send_frame(32'h00000001, 8'h00);
        check("sat_ecnt", {24'h0, err_count}, 32'hFF);
        send_frame(32'h00000001, 8'h00);
        check("sat_fe",   {31'h0, frame_err}, 32'h1);
        check("sat_code", {30'h0, err_code}, 32'h1);
        check("sat_hold", {24'h0, err_count}, 32'hFF);
        check("sat_price", price_out, 32'h0);

        @(posedge clk); #1;
        check("never_both", {31'h0, both_seen}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/price_frame_rx.md
PRICE_FRAME_RX -- requirements
Module: price_frame_rx

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 52_083, inter-byte timeout in clk cycles (10 bit-times at 9600 baud / 50 MHz); legal range 2..2^20-1.
REQ-002 Port: clk  input  1  single clock; all logic on posedge clk.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: rx_data  input  8  received byte from UART receiver; valid only when rx_ready=1.
REQ-005 Port: rx_ready  input  1  one-cycle strobe, one per received byte.
REQ-006 Port: price_out  output  32  last accepted price, big-endian reassembled.
REQ-007 Port: price_valid  output  1  one-cycle pulse; price_out holds the new price in that cycle.
REQ-008 Port: frame_err  output  1  one-cycle pulse on checksum failure or timeout.
REQ-009 Port: err_code  output  2  cause of last error: 0 none, 1 checksum, 2 timeout; held until the next error or reset.
REQ-010 Port: frame_count  output  16  count of accepted frames; wraps 0xFFFF->0x0000.
REQ-011 Port: err_count  output  8  count of frame_err pulses; saturates at 0xFF.

Function
REQ-012 Frame format: SYNC=0xA5, P3 (MSB), P2, P1, P0 (LSB), CHK; CHK SHALL equal P3^P2^P1^P0.
REQ-013 FSM states: HUNT, GET_P3, GET_P2, GET_P1, GET_P0, GET_CHK; reset state HUNT.
REQ-014 HUNT: rx_ready with rx_data=0xA5 -> GET_P3; any other byte discarded silently; no error, no counter change.
REQ-015 GET_P3..GET_P0: each rx_ready stores the byte into its slot of a 32-bit shadow register and advances one state; 0xA5 is treated as data in these states.
REQ-016 GET_CHK with rx_ready: if CHK matches, price_out <= shadow and price_valid=1 in the next cycle, frame_count +1; else frame_err=1 in the next cycle, err_code=1, err_count +1 (saturating), price_out unchanged. Both outcomes -> HUNT.
REQ-017 Latency: price_valid is asserted exactly 1 cycle after the rx_ready cycle carrying CHK.
REQ-018 Timeout counter: cleared on every rx_ready and on entering HUNT; increments each cycle while in GET_P3..GET_CHK and rx_ready=0.
REQ-019 Timeout: when the counter reaches TIMEOUT_CYCLES in a non-HUNT state -> HUNT, frame_err=1 next cycle, err_code=2, err_count +1 (saturating), shadow discarded, price_out unchanged.
REQ-020 Simultaneous rx_ready and timeout terminal count: the byte wins; no timeout is raised.
REQ-021 A byte that arrives in the cycle the FSM returns to HUNT (after CHK or timeout) is evaluated under HUNT rules.
REQ-022 price_valid and frame_err SHALL never both be 1 in the same cycle.
REQ-023 Frame accepted and frame_count wrap: 0xFFFF -> 0x0000 with price_valid still asserted.
REQ-024 err_count at 0xFF stays 0xFF on further errors; frame_err and err_code still update.

Reset
REQ-025 On rst=1 at a clock edge: state HUNT, price_out=0, price_valid=0, frame_err=0, err_code=0, frame_count=0, err_count=0, timeout counter=0, shadow=0.
REQ-026 Reset mid-frame abandons the partial frame with no pulse; rx_ready during a reset cycle is ignored.
REQ-027 Outputs take reset values in the cycle after the reset edge and hold until a new event.

Verification
REQ-028 Bytes A5 00 01 86 A0 27 -> price_valid one cycle after the 0x27 strobe, price_out=0x000186A0, frame_count=1, frame_err never set.
REQ-029 Bytes A5 00 01 86 A0 00 -> frame_err pulse, err_code=1, err_count=1, price_out unchanged, no price_valid.
REQ-030 TIMEOUT_CYCLES=16; A5 12 34 then 16 idle cycles -> frame_err, err_code=2; then full valid frame A5 11 22 33 44 44 -> price_out=0x11223344.
REQ-031 Bytes 00 FF 3C A5 DE AD BE EF 22 -> leading garbage ignored, price_out=0xDEADBEEF, err_count=0.
REQ-032 rst asserted after A5 12; then A5 00 00 00 07 07 -> no pulse during reset; price_out=0x00000007, frame_count=1.
REQ-033 Preload frame_count=0xFFFF via 65535 valid frames (or force), one more valid frame -> frame_count=0x0000, price_valid=1; 256 bad-CHK frames -> err_count=0xFF.
